// File: rtl/therm_pkg.sv
// Shared types and helpers for the ring-oscillator thermometer scan controller.
// Optional build macro THERM_HDR_EN adds the channel-ID header state.
package therm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETTLE,
        ST_GATE,
        ST_CAPTURE,
`ifdef THERM_HDR_EN
        ST_SEND_HDR,
`endif
        ST_SEND_DATA,
        ST_WAIT_TX,
        ST_NEXT
    } therm_state_t;

    localparam logic [3:0] THERM_HDR_TAG = 4'hA;

    // Counts above one byte clip to 0xFF rather than wrapping.
    function automatic logic [7:0] sat8(input logic [31:0] cnt);
        return (cnt > 32'd255) ? 8'hFF : cnt[7:0];
    endfunction

endpackage

// File: rtl/therm_win_timer.sv
// Loadable down-counter shared by the settle and gate windows; done_o pulses
// in the last cycle of a loaded interval of (load_val_i + 1) cycles.
module therm_win_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic         armed_q;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else if (load_i) begin
            cnt_q   <= load_val_i;
            armed_q <= 1'b1;
        end else if (armed_q) begin
            if (cnt_q == '0) begin
                armed_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign done_o = armed_q && (cnt_q == '0);

endmodule

// File: rtl/therm_scan_ctrl.sv
// Round-robin measurement sequencer: enable, clear, gate, capture, send one byte
// per channel to the UART. Define THERM_HDR_EN to precede each byte with a header.
module therm_scan_ctrl
    import therm_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 16,
    parameter int GATE_CYCLES   = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    preset_en,
    input  logic [7:0]              preset_val,
    output logic [N_CH-1:0]         ch_en,
    output logic                    cnt_clr,
    output logic                    cnt_gate,
    input  logic [CNT_W-1:0]        cnt_val,
    output logic [7:0]              tx_data,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic [$clog2(N_CH)-1:0] cur_ch,
    output logic                    busy
);

    localparam int CH_W    = $clog2(N_CH);
    localparam int TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(N_CH - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LD    = TMR_W'(GATE_CYCLES - 1);

    therm_state_t     state_q, state_d;
    logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
    logic [7:0]       byte_q, byte_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [N_CH-1:0]  ch_en_q, ch_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             cnt_gate_q, cnt_gate_d;
    logic             tx_start_q, tx_start_d;
    logic             busy_q, busy_d;
    logic             seen_busy_q, seen_busy_d;
`ifdef THERM_HDR_EN
    logic             hdr_sent_q, hdr_sent_d;
`endif

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    therm_win_timer #(
        .W (TMR_W)
    ) u_win_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        byte_d      = byte_q;
        seen_busy_d = seen_busy_q;
`ifdef THERM_HDR_EN
        hdr_sent_d  = hdr_sent_q;
`endif
        tmr_load    = 1'b0;
        tmr_val     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (en && !tx_busy) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
            end
            ST_SETTLE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (tmr_done) begin
                    state_d  = ST_GATE;
                    tmr_load = 1'b1;
                    tmr_val  = GATE_LD;
                end
            end
            ST_GATE: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (tmr_done) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                byte_d = preset_en ? preset_val : sat8(32'(cnt_val));
`ifdef THERM_HDR_EN
                state_d = ST_SEND_HDR;
`else
                state_d = ST_SEND_DATA;
`endif
            end
`ifdef THERM_HDR_EN
            ST_SEND_HDR: begin
                hdr_sent_d  = 1'b1;
                seen_busy_d = 1'b0;
                state_d     = ST_WAIT_TX;
            end
`endif
            ST_SEND_DATA: begin
`ifdef THERM_HDR_EN
                hdr_sent_d  = 1'b0;
`endif
                seen_busy_d = 1'b0;
                state_d     = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // Only a high-then-low busy counts as end of byte.
                if (tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
`ifdef THERM_HDR_EN
                    state_d = hdr_sent_q ? ST_SEND_DATA : ST_NEXT;
`else
                    state_d = ST_NEXT;
`endif
                end
            end
            ST_NEXT: begin
                cur_ch_d = (cur_ch_q == LAST_CH) ? '0 : cur_ch_q + 1'b1;
                state_d  = en ? ST_CLEAR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state and registered below.
        ch_en_d = '0;
        if (state_d inside {ST_CLEAR, ST_SETTLE, ST_GATE}) ch_en_d[cur_ch_d] = 1'b1;
        cnt_clr_d  = (state_d == ST_CLEAR);
        cnt_gate_d = (state_d == ST_GATE);
        busy_d     = (state_d != ST_IDLE);
        tx_start_d = (state_d == ST_SEND_DATA);
        tx_data_d  = tx_data_q;
        if (state_d == ST_SEND_DATA) tx_data_d = byte_d;
`ifdef THERM_HDR_EN
        if (state_d == ST_SEND_HDR) begin
            tx_start_d = 1'b1;
            tx_data_d  = {THERM_HDR_TAG, 4'(cur_ch_d)};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cur_ch_q    <= '0;
            byte_q      <= 8'h00;
            tx_data_q   <= 8'h00;
            ch_en_q     <= '0;
            cnt_clr_q   <= 1'b0;
            cnt_gate_q  <= 1'b0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
            seen_busy_q <= 1'b0;
`ifdef THERM_HDR_EN
            hdr_sent_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            byte_q      <= byte_d;
            tx_data_q   <= tx_data_d;
            ch_en_q     <= ch_en_d;
            cnt_clr_q   <= cnt_clr_d;
            cnt_gate_q  <= cnt_gate_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
            seen_busy_q <= seen_busy_d;
`ifdef THERM_HDR_EN
            hdr_sent_q  <= hdr_sent_d;
`endif
        end
    end

    assign ch_en    = ch_en_q;
    assign cnt_clr  = cnt_clr_q;
    assign cnt_gate = cnt_gate_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign cur_ch   = cur_ch_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_therm_scan_ctrl.sv
// Self-checking bench for therm_scan_ctrl: table-driven scans plus hand-written
// abort/reset sequences, with a byte scoreboard fed by a UART busy model.
`timescale 1ns/1ps
module tb_therm_scan_ctrl;

    localparam int N_CH     = 2;
    localparam int CNT_W    = 16;
    localparam int S_CYC    = 4;
    localparam int G_CYC    = 50;
    localparam int BUSY_LEN = 20;
`ifdef THERM_HDR_EN
    localparam int BPC = 2;
`else
    localparam int BPC = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             preset_en;
    logic [7:0]       preset_val;
    logic [N_CH-1:0]  ch_en;
    logic             cnt_clr;
    logic             cnt_gate;
    logic [CNT_W-1:0] cnt_val;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             tx_busy;
    logic [0:0]       cur_ch;
    logic             busy;

    logic [CNT_W-1:0] stub_val [N_CH];
    logic [7:0]       sb_q [$];
    int               tests_run = 0;
    int               tests_failed = 0;
    int               starts = 0;
    int               cyc = 0;
    int               busy_cnt = 0;
    logic             gate_check_en = 1'b1;

    typedef struct {
        logic [15:0] v0;
        logic [15:0] v1;
        logic        pe;
        logic [7:0]  pv;
        logic [7:0]  e0;
        logic [7:0]  e1;
    } vec_t;

    therm_scan_ctrl #(
        .N_CH          (N_CH),
        .CNT_W         (CNT_W),
        .SETTLE_CYCLES (S_CYC),
        .GATE_CYCLES   (G_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .preset_en  (preset_en),
        .preset_val (preset_val),
        .ch_en      (ch_en),
        .cnt_clr    (cnt_clr),
        .cnt_gate   (cnt_gate),
        .cnt_val    (cnt_val),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .cur_ch     (cur_ch),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign cnt_val = stub_val[cur_ch];

    // UART model: busy rises the cycle after tx_start and holds BUSY_LEN cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst)                            busy_cnt <= 0;
        else if (tx_start && busy_cnt == 0)  busy_cnt <= BUSY_LEN;
        else if (busy_cnt > 0)               busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests_run++;
        if (act !== exp_v) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic push_frames(input int first_ch, input int n, input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < n; i++) begin
            int ch = (first_ch + i) % N_CH;
`ifdef THERM_HDR_EN
            sb_q.push_back({4'hA, 4'(ch)});
`endif
            sb_q.push_back((ch == 0) ? b0 : b1);
        end
    endtask

    task automatic wait_starts(input int n, input string name);
        int target = starts + n;
        for (int k = 0; k < n * 200; k++) begin
            if (starts >= target) break;
            @(negedge clk);
        end
        tests_run++;
        if (starts < target) begin
            tests_failed++;
            $display("FAIL %s: timeout, tx_start count %0d, required %0d", name, starts, target);
        end
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 300; k++) begin
            if (!busy && !tx_busy) break;
            @(negedge clk);
        end
        check(name, busy, 0);
    endtask

    task automatic wait_high(input bit gate_not_clr, input string name);
        logic seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            seen = gate_not_clr ? cnt_gate : cnt_clr;
            if (seen) break;
            @(negedge clk);
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL %s: timeout waiting for pulse, got 0, expected 1", name);
        end
    endtask

    // Scoreboard pop plus window-timing checks, sampled on the falling edge.
    int   gate_len = 0, clr_cyc = 0, rise_cyc = 0;
    logic gate_prev = 1'b0, pend_start = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            gate_prev  = 1'b0;
            pend_start = 1'b0;
        end else begin
            if (tx_start) begin
                starts++;
                check("start_while_busy", tx_busy, 0);
                if (sb_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL tx_byte: unexpected tx_start, data 0x%0h, expected none", tx_data);
                end else begin
                    check("tx_byte", tx_data, sb_q.pop_front());
                end
                if (pend_start) check("gate_to_start", cyc - rise_cyc, G_CYC + 1);
                pend_start = 1'b0;
            end
            if (cnt_clr) clr_cyc = cyc;
            if (cnt_gate && !gate_prev) begin
                rise_cyc = cyc;
                gate_len = 0;
                if (gate_check_en) check("clr_to_gate", cyc - clr_cyc, S_CYC + 1);
            end
            if (cnt_gate) gate_len++;
            if (!cnt_gate && gate_prev && gate_check_en) begin
                check("gate_len", gate_len, G_CYC);
                pend_start = 1'b1;
            end
            gate_prev = cnt_gate;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ch_en"},    ch_en,    0);
        check({tag, "_cnt_clr"},  cnt_clr,  0);
        check({tag, "_cnt_gate"}, cnt_gate, 0);
        check({tag, "_tx_start"}, tx_start, 0);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_tx_data"},  tx_data,  0);
        check({tag, "_cur_ch"},   cur_ch,   0);
    endtask

    initial begin
        vec_t vecs [5];
        int   n0;
        vecs[0] = '{16'h0023, 16'h0041, 1'b0, 8'h00, 8'h23, 8'h41};
        vecs[1] = '{16'h0100, 16'h00FF, 1'b0, 8'h00, 8'hFF, 8'hFF};
        vecs[2] = '{16'h0000, 16'hFFFF, 1'b0, 8'h00, 8'h00, 8'hFF};
        vecs[3] = '{16'h1234, 16'h0007, 1'b1, 8'hFF, 8'hFF, 8'hFF};
        vecs[4] = '{16'h0080, 16'h0001, 1'b1, 8'h5A, 8'h5A, 8'h5A};

        rst = 1'b0; en = 1'b0; preset_en = 1'b0; preset_val = 8'h00;
        stub_val[0] = '0; stub_val[1] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b1;
        @(negedge clk);

        // Table: one full two-channel scan per vector, en dropped during the last frame.
        for (int i = 0; i < 5; i++) begin
            stub_val[0] = vecs[i].v0;
            stub_val[1] = vecs[i].v1;
            preset_en   = vecs[i].pe;
            preset_val  = vecs[i].pv;
            push_frames(0, 2, vecs[i].e0, vecs[i].e1);
            en = 1'b1;
            wait_starts(BPC, "vec_ch0");
            check("vec_cur_ch0", cur_ch, 0);
            wait_starts(BPC, "vec_ch1");
            en = 1'b0;
            check("vec_cur_ch1", cur_ch, 1);
            wait_idle("vec_idle");
            check("vec_wrap", cur_ch, 0);
            preset_en = 1'b0;
        end

        // Continuous scan across the wrap: ch0, ch1, ch0, ch1.
        stub_val[0] = 16'h0023;
        stub_val[1] = 16'h0041;
        push_frames(0, 4, 8'h23, 8'h41);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_starts(BPC, "scan_start");
            check("scan_cur_ch", cur_ch, i % 2);
        end
        en = 1'b0;
        wait_idle("scan_idle");

        // Preset pulse confined to SETTLE must not affect the captured byte.
        preset_val = 8'hFF;
        push_frames(0, 1, 8'h23, 8'h00);
        en = 1'b1;
        wait_high(1'b0, "pulse_clr");
        @(negedge clk);
        preset_en = 1'b1;
        repeat (3) @(negedge clk);
        preset_en = 1'b0;
        wait_starts(BPC, "pulse_start");
        en = 1'b0;
        wait_idle("pulse_idle");
        check("pulse_next_ch", cur_ch, 1);

        // Enable drop at gate cycle 10 on ch1, then restart of the same channel.
        en = 1'b1;
        wait_high(1'b1, "drop_gate_rise");
        gate_check_en = 1'b0;
        repeat (9) @(negedge clk);
        n0 = starts;
        en = 1'b0;
        @(negedge clk);
        check("drop_gate", cnt_gate, 0);
        check("drop_ch_en", ch_en, 0);
        check("drop_busy", busy, 0);
        check("drop_cur_ch", cur_ch, 1);
        repeat (100) @(negedge clk);
        check("drop_no_tx", starts, n0);
        push_frames(1, 1, 8'h00, 8'h41);
        en = 1'b1;
        gate_check_en = 1'b1;
        wait_high(1'b0, "restart_clr");
        check("restart_ch_en", ch_en, 2'b10);
        check("restart_cur_ch", cur_ch, 1);
        wait_starts(BPC, "restart_start");
        en = 1'b0;
        wait_idle("restart_idle");
        check("restart_wrap", cur_ch, 0);

        // Advance to ch1, then assert reset asynchronously mid-gate.
        stub_val[0] = 16'h0010;
        push_frames(0, 1, 8'h10, 8'h00);
        en = 1'b1;
        wait_starts(BPC, "pre_rst_start");
        en = 1'b0;
        wait_idle("pre_rst_idle");
        check("pre_rst_cur_ch", cur_ch, 1);
        en = 1'b1;
        wait_high(1'b1, "rst_gate_rise");
        repeat (5) @(negedge clk);
        gate_check_en = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        repeat (3) @(negedge clk);
        check_reset_outputs("held_rst");
        stub_val[0] = 16'h0033;
        stub_val[1] = 16'h0200;
        push_frames(0, 2, 8'h33, 8'hFF);
        gate_check_en = 1'b1;
        rst = 1'b1;
        wait_starts(2 * BPC, "post_rst_start");
        en = 1'b0;
        wait_idle("post_rst_idle");
        check("post_rst_cur_ch", cur_ch, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
